// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the RV32I pipeline.
// Owns the PC, looks it up in a direct-mapped BTB with 2-bit saturating
// counters to pick the next PC, and registers the fetched instruction into
// the IF/ID pipeline register. EX trains the BTB and redirects on mispredict.
//
// Handshake: o_id_valid = 1 means IF/ID holds a real instruction. There is
// no ready; i_stall is the back-pressure and freezes PC and IF/ID entirely.
// i_redirect overrides i_stall and loads IF/ID with a bubble.
module fetch_unit #(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_pc_fetch,
  input  logic [31:0] i_inst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_inst,
  output logic        o_id_pred_taken,
  output logic [31:0] o_id_pred_target
);

  localparam int          IDX = $clog2(BTB_ENTRIES);
  localparam int          TW  = 30 - IDX;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // BTB storage: targets keep only bits [31:2] since they are word-aligned
  logic            r_btb_valid  [BTB_ENTRIES];
  logic [TW-1:0]   r_btb_tag    [BTB_ENTRIES];
  logic [29:0]     r_btb_target [BTB_ENTRIES];
  logic [1:0]      r_btb_ctr    [BTB_ENTRIES];

  logic [31:0]     r_pc;
  logic            r_id_valid;
  logic [31:0]     r_id_pc;
  logic [31:0]     r_id_inst;
  logic            r_id_pred_taken;
  logic [31:0]     r_id_pred_target;

  logic [IDX-1:0]  w_lk_idx;
  logic [TW-1:0]   w_lk_tag;
  logic            w_lk_hit;
  logic            w_pred_taken;
  logic [31:0]     w_pred_next;

  logic [IDX-1:0]  w_upd_idx;
  logic [TW-1:0]   w_upd_tag;
  logic            w_upd_hit;
  logic [1:0]      w_upd_ctr;
  logic [1:0]      w_upd_ctr_next;

  // Lookup on the current PC; sees pre-update BTB contents by construction
  always_comb begin
    w_lk_idx     = r_pc[IDX+1:2];
    w_lk_tag     = r_pc[31:IDX+2];
    w_lk_hit     = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    w_pred_taken = w_lk_hit && r_btb_ctr[w_lk_idx][1];
    w_pred_next  = w_pred_taken ? {r_btb_target[w_lk_idx], 2'b00} : (r_pc + 32'd4);
  end

  // Update-side hit detection and saturating counter step
  always_comb begin
    w_upd_idx      = i_upd_pc[IDX+1:2];
    w_upd_tag      = i_upd_pc[31:IDX+2];
    w_upd_hit      = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);
    w_upd_ctr      = r_btb_ctr[w_upd_idx];
    w_upd_ctr_next = w_upd_ctr;
    if (i_upd_taken) begin
      if (w_upd_ctr != 2'b11) w_upd_ctr_next = w_upd_ctr + 2'd1;
    end else begin
      if (w_upd_ctr != 2'b00) w_upd_ctr_next = w_upd_ctr - 2'd1;
    end
  end

  // BTB training from EX; independent of stall and redirect
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb_valid[i]  <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= '0;
        r_btb_ctr[i]    <= 2'b01;
      end
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        r_btb_ctr[w_upd_idx] <= w_upd_ctr_next;
        if (i_upd_taken) r_btb_target[w_upd_idx] <= i_upd_target[31:2];
      end else if (i_upd_taken) begin
        // Allocate, evicting whatever aliased into this slot
        r_btb_valid[w_upd_idx]  <= 1'b1;
        r_btb_tag[w_upd_idx]    <= w_upd_tag;
        r_btb_target[w_upd_idx] <= i_upd_target[31:2];
        r_btb_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

  // PC and IF/ID register: redirect beats stall beats normal fetch
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc             <= RESET_PC;
      r_id_valid       <= 1'b0;
      r_id_pc          <= 32'd0;
      r_id_inst        <= NOP;
      r_id_pred_taken  <= 1'b0;
      r_id_pred_target <= 32'd0;
    end else if (i_redirect) begin
      r_pc             <= {i_redirect_pc[31:2], 2'b00};
      r_id_valid       <= 1'b0;
      r_id_pc          <= 32'd0;
      r_id_inst        <= NOP;
      r_id_pred_taken  <= 1'b0;
      r_id_pred_target <= 32'd0;
    end else if (!i_stall) begin
      r_pc             <= w_pred_next;
      r_id_valid       <= 1'b1;
      r_id_pc          <= r_pc;
      r_id_inst        <= i_inst;
      r_id_pred_taken  <= w_pred_taken;
      r_id_pred_target <= w_pred_next;
    end
  end

  assign o_pc_fetch       = r_pc;
  assign o_id_valid       = r_id_valid;
  assign o_id_pc          = r_id_pc;
  assign o_id_inst        = r_id_inst;
  assign o_id_pred_taken  = r_id_pred_taken;
  assign o_id_pred_target = r_id_pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a
// behavioural model of the fetch stage (PC, IF/ID and BTB tables).
module tb_fetch_unit;

  localparam int          N   = 16;
  localparam int          IDX = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] o_pc_fetch;
  logic [31:0] i_inst;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic        i_upd_taken = 1'b0;
  logic [31:0] i_upd_target = '0;
  logic        o_id_valid;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_inst;
  logic        o_id_pred_taken;
  logic [31:0] o_id_pred_target;

  int n_cmp = 0;
  int n_err = 0;

  // Instruction memory: word k holds value k
  assign i_inst = {2'b00, o_pc_fetch[31:2]};

  fetch_unit #(.BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .o_pc_fetch(o_pc_fetch), .i_inst(i_inst),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_target(i_upd_target), .o_id_valid(o_id_valid), .o_id_pc(o_id_pc),
    .o_id_inst(o_id_inst), .o_id_pred_taken(o_id_pred_taken),
    .o_id_pred_target(o_id_pred_target)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_id_valid;
  logic [31:0] m_id_pc, m_id_inst, m_id_ptgt;
  logic        m_id_pt;
  bit          m_valid [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];

  task automatic model_reset();
    m_pc = 32'h0; m_id_valid = 0; m_id_pc = 0; m_id_inst = NOP;
    m_id_pt = 0; m_id_ptgt = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
  endtask

  // Driver: apply inputs for one cycle, advance model across the edge
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt);
    int li, ui;
    logic hit, uhit, ptk;
    logic [31:0] pnext;
    i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;
    i_upd_valid = uv; i_upd_pc = upc; i_upd_taken = ut; i_upd_target = utgt;
    li    = int'((m_pc >> 2) % N);
    hit   = m_valid[li] && (m_tag[li] == (m_pc >> (IDX + 2)));
    ptk   = hit && (m_ctr[li] >= 2);
    pnext = ptk ? m_tgt[li] : m_pc + 32'd4;
    ui    = int'((upc >> 2) % N);
    uhit  = m_valid[ui] && (m_tag[ui] == (upc >> (IDX + 2)));
    @(posedge i_clk); #1;
    if (redir) begin
      m_pc = rpc & ~32'd3;
      m_id_valid = 0; m_id_inst = NOP; m_id_pt = 0;
    end else if (!stall) begin
      m_id_valid = 1; m_id_pc = m_pc; m_id_inst = m_pc >> 2;
      m_id_pt = ptk; m_id_ptgt = pnext; m_pc = pnext;
    end
    if (uv) begin
      if (uhit) begin
        m_ctr[ui] = ut ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                       : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
        if (ut) m_tgt[ui] = utgt & ~32'd3;
      end else if (ut) begin
        m_valid[ui] = 1; m_tag[ui] = upc >> (IDX + 2);
        m_tgt[ui] = utgt & ~32'd3; m_ctr[ui] = 2;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    cycle(0, 0, 0, 1, pc, taken, tgt);
  endtask

  task automatic redirect(input logic [31:0] pc);
    cycle(0, 1, pc, 0, 0, 0, 0);
  endtask

  // Reset asserted between edges; released between edges
  task automatic do_reset();
    i_stall = 0; i_redirect = 0; i_upd_valid = 0;
    i_reset = 1; #1;
    model_reset();
    @(posedge i_clk); #1;
    i_reset = 0;
  endtask

  task automatic test_reset();
    idle(3);
    i_reset = 1; #1;
    n_cmp++; if (o_pc_fetch !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", o_pc_fetch, 32'h0); end
    n_cmp++; if ({o_id_valid, o_id_pc, o_id_inst, o_id_pred_taken, o_id_pred_target} !== {1'b0, 32'h0, NOP, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_id: got v=%b pc=%h inst=%h pt=%b ptg=%h", o_id_valid, o_id_pc, o_id_inst, o_id_pred_taken, o_id_pred_target);
    end
    model_reset();
    @(posedge i_clk); #1;
    i_reset = 0;
  endtask

  task automatic test_seq_fetch();
    do_reset();
    idle(1);
    n_cmp++; if (o_pc_fetch !== 32'h4) begin n_err++; $display("FAIL seq_pc1: got %h want %h", o_pc_fetch, 32'h4); end
    n_cmp++; if ({o_id_valid, o_id_pc, o_id_inst, o_id_pred_taken, o_id_pred_target} !== {1'b1, 32'h0, 32'h0, 1'b0, 32'h4}) begin
      n_err++; $display("FAIL seq_id1: got v=%b pc=%h inst=%h pt=%b ptg=%h", o_id_valid, o_id_pc, o_id_inst, o_id_pred_taken, o_id_pred_target);
    end
    idle(1);
    n_cmp++; if (o_pc_fetch !== 32'h8) begin n_err++; $display("FAIL seq_pc2: got %h want %h", o_pc_fetch, 32'h8); end
    n_cmp++; if ({o_id_pc, o_id_inst, o_id_pred_target} !== {32'h4, 32'h1, 32'h8}) begin
      n_err++; $display("FAIL seq_id2: got pc=%h inst=%h ptg=%h", o_id_pc, o_id_inst, o_id_pred_target);
    end
  endtask

  task automatic test_stall();
    do_reset();
    idle(4);
    n_cmp++; if (o_pc_fetch !== 32'h10) begin n_err++; $display("FAIL stall_setup: got %h want %h", o_pc_fetch, 32'h10); end
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 0, 0, 0, 0);
      n_cmp++; if ({o_pc_fetch, o_id_valid, o_id_pc, o_id_inst, o_id_pred_target} !== {32'h10, 1'b1, 32'hC, 32'h3, 32'h10}) begin
        n_err++; $display("FAIL stall_hold%0d: got pc=%h v=%b idpc=%h inst=%h ptg=%h", k, o_pc_fetch, o_id_valid, o_id_pc, o_id_inst, o_id_pred_target);
      end
    end
    idle(1);
    n_cmp++; if ({o_pc_fetch, o_id_pc} !== {32'h14, 32'h10}) begin
      n_err++; $display("FAIL stall_resume: got pc=%h idpc=%h want 14/10", o_pc_fetch, o_id_pc);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    idle(2);
    cycle(1, 1, 32'h43, 0, 0, 0, 0);
    n_cmp++; if ({o_pc_fetch, o_id_valid, o_id_inst, o_id_pred_taken} !== {32'h40, 1'b0, NOP, 1'b0}) begin
      n_err++; $display("FAIL redir_bubble: got pc=%h v=%b inst=%h pt=%b", o_pc_fetch, o_id_valid, o_id_inst, o_id_pred_taken);
    end
    idle(1);
    n_cmp++; if ({o_pc_fetch, o_id_valid, o_id_pc, o_id_inst} !== {32'h44, 1'b1, 32'h40, 32'h10}) begin
      n_err++; $display("FAIL redir_target: got pc=%h v=%b idpc=%h inst=%h", o_pc_fetch, o_id_valid, o_id_pc, o_id_inst);
    end
  endtask

  task automatic test_btb_learn();
    do_reset();
    upd(32'h10, 1, 32'h80);
    redirect(32'h10);
    idle(1);
    n_cmp++; if ({o_pc_fetch, o_id_pc, o_id_pred_taken, o_id_pred_target} !== {32'h80, 32'h10, 1'b1, 32'h80}) begin
      n_err++; $display("FAIL btb_learn: got pc=%h idpc=%h pt=%b ptg=%h", o_pc_fetch, o_id_pc, o_id_pred_taken, o_id_pred_target);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 4; k++) upd(32'h10, 1, 32'h80);
    redirect(32'h10); idle(1);
    n_cmp++; if (o_pc_fetch !== 32'h80) begin n_err++; $display("FAIL sat_taken: got %h want %h", o_pc_fetch, 32'h80); end
    for (int k = 0; k < 2; k++) upd(32'h10, 0, 32'h0);
    redirect(32'h10); idle(1);
    n_cmp++; if ({o_pc_fetch, o_id_pred_taken} !== {32'h14, 1'b0}) begin
      n_err++; $display("FAIL sat_decay: got pc=%h pt=%b want 14/0", o_pc_fetch, o_id_pred_taken);
    end
    for (int k = 0; k < 3; k++) upd(32'h10, 0, 32'h0);
    upd(32'h10, 1, 32'h80);
    redirect(32'h10); idle(1);
    n_cmp++; if (o_pc_fetch !== 32'h14) begin n_err++; $display("FAIL sat_floor: got %h want %h", o_pc_fetch, 32'h14); end
  endtask

  task automatic test_alias();
    do_reset();
    upd(32'h10, 1, 32'h80);
    upd(32'h50, 1, 32'hC0);
    redirect(32'h10); idle(1);
    n_cmp++; if (o_pc_fetch !== 32'h14) begin n_err++; $display("FAIL alias_evicted: got %h want %h", o_pc_fetch, 32'h14); end
    redirect(32'h50); idle(1);
    n_cmp++; if ({o_pc_fetch, o_id_pred_taken} !== {32'hC0, 1'b1}) begin
      n_err++; $display("FAIL alias_new: got pc=%h pt=%b want c0/1", o_pc_fetch, o_id_pred_taken);
    end
  endtask

  task automatic test_same_cycle_and_wrap();
    do_reset();
    redirect(32'h20);
    upd(32'h20, 1, 32'h100);
    n_cmp++; if (o_pc_fetch !== 32'h24) begin n_err++; $display("FAIL same_cycle_old: got %h want %h", o_pc_fetch, 32'h24); end
    redirect(32'h20); idle(1);
    n_cmp++; if (o_pc_fetch !== 32'h100) begin n_err++; $display("FAIL same_cycle_new: got %h want %h", o_pc_fetch, 32'h100); end
    redirect(32'hFFFF_FFFF);
    n_cmp++; if (o_pc_fetch !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_align: got %h want %h", o_pc_fetch, 32'hFFFF_FFFC); end
    idle(1);
    n_cmp++; if ({o_pc_fetch, o_id_pc, o_id_pred_target} !== {32'h0, 32'hFFFF_FFFC, 32'h0}) begin
      n_err++; $display("FAIL wrap_pc: got pc=%h idpc=%h ptg=%h", o_pc_fetch, o_id_pc, o_id_pred_target);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc, upc, utgt;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      rpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 255));
      upc  = 32'($urandom_range(0, 63)) << 2;
      utgt = 32'($urandom_range(0, 255));
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, rpc,
            $urandom_range(0, 2) != 0, upc, $urandom_range(0, 2) != 0, utgt);
      n_cmp++; if (o_pc_fetch !== m_pc) begin
        n_err++; $display("FAIL rand_pc c=%0d: got %h want %h", c, o_pc_fetch, m_pc);
      end
      n_cmp++; if ({o_id_valid, o_id_inst, o_id_pred_taken} !== {m_id_valid, m_id_inst, m_id_pt} ||
                   (m_id_valid && {o_id_pc, o_id_pred_target} !== {m_id_pc, m_id_ptgt})) begin
        n_err++; $display("FAIL rand_id c=%0d: got v=%b pc=%h inst=%h pt=%b ptg=%h want v=%b pc=%h inst=%h pt=%b ptg=%h",
                          c, o_id_valid, o_id_pc, o_id_inst, o_id_pred_taken, o_id_pred_target,
                          m_id_valid, m_id_pc, m_id_inst, m_id_pt, m_id_ptgt);
      end
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    test_reset();
    test_seq_fetch();
    test_stall();
    test_redirect_stall();
    test_btb_learn();
    test_saturation();
    test_alias();
    test_same_cycle_and_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
